rr_arbiter16: RTL and testbench

Sixteen-way round-robin arbiter that shares a single downstream resource among 16 requesters. It issues at most one grant at a time, as a one-hot 16-bit vector plus its 4-bit index; the one-hot vector is the 4-to-16 decode of the index. A hold-time limit prevents any requester from monopolising the resource. It sits between the requester bank and the shared resource's select/enable logic.

---
 rtl/rr_arbiter16.sv | 85 ++++++++
 tb/tb_rr_arbiter16.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter16.sv
// ============================================================================
// Module   : rr_arbiter16
// Function : 16-way round-robin arbiter with a per-grant hold-time limit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter16 #(
  parameter int MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] c_last_cnt = 8'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [3:0] r_ptr;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt_id;
  logic       r_timeout;

  logic [3:0] w_winner;
  logic       w_cnt_hit;
  logic       w_normal_rel;
  logic       w_release;

  // Scan downward through offsets so the smallest offset from r_ptr wins.
  always_comb begin
    w_winner = r_ptr;
    for (int i = 15; i >= 0; i--) begin
      if (req[r_ptr + 4'(i)]) begin
        w_winner = r_ptr + 4'(i);
      end
    end
  end

  assign w_cnt_hit    = (r_cnt == c_last_cnt);
  assign w_normal_rel = done | ~req[r_gnt_id];
  assign w_release    = w_normal_rel | w_cnt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 4'd0;
      r_cnt     <= 8'd0;
      r_gnt_id  <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        if (|req) begin
          r_state  <= GRANT;
          r_gnt_id <= w_winner;
          r_cnt    <= 8'd0;
        end
      end else begin
        if (w_release) begin
          r_state   <= IDLE;
          r_ptr     <= r_gnt_id + 4'd1;
          // Only a pure hold-limit expiry counts as a forced revocation.
          r_timeout <= ~w_normal_rel;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign gnt_valid = (r_state == GRANT);
  assign gnt_id    = r_gnt_id;
  assign gnt       = gnt_valid ? (16'b1 << r_gnt_id) : 16'b0;
  assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter16.sv
// ============================================================================
// Module   : tb_rr_arbiter16
// Function : Directed self-checking bench for rr_arbiter16 (MAX_HOLD=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;

  int n_vec;
  int n_err;

  rr_arbiter16 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_gnt, input logic [3:0] e_id,
                         input logic e_valid, input logic e_to);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".id"}, {12'd0, gnt_id}, {12'd0, e_id});
    chk({tag, ".valid"}, {15'd0, gnt_valid}, {15'd0, e_valid});
    chk({tag, ".timeout"}, {15'd0, timeout}, {15'd0, e_to});
  endtask

  initial begin
    logic [3:0] exp_id;
    n_vec = 0;
    n_err = 0;

    // Reset with every requester active
    rst  = 1'b1;
    req  = 16'hFFFF;
    done = 1'b0;
    #1;
    chk_all("rst0", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_all("rst1", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_all("rst2", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("first", 16'h0001, 4'd0, 1'b1, 1'b0);

    // Release id 0, then single request from id 5 (ptr=1)
    done = 1'b1;
    tick();
    chk_all("rel0", 16'h0000, 4'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 16'h0020;
    tick();
    chk_all("single5", 16'h0020, 4'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_all("rel5", 16'h0000, 4'd5, 1'b0, 1'b0);
    done = 1'b0;
    req  = 16'hFFFF;
    tick();
    chk_all("after5", 16'h0040, 4'd6, 1'b1, 1'b0);

    // Rotation with all requesting: ids 7..15,0..6 then 7..13
    for (int k = 1; k <= 23; k++) begin
      exp_id = 4'(6 + k);
      done = 1'b1;
      tick();
      chk("rot.gap", {15'd0, gnt_valid}, 16'h0000);
      done = 1'b0;
      tick();
      chk("rot.id", {12'd0, gnt_id}, {12'd0, exp_id});
      chk("rot.gnt", gnt, 16'h0001 << exp_id);
    end

    // Wrap-around: release id 13 (ptr=14), req 2004 -> 2 then 13
    done = 1'b1;
    req  = 16'h2004;
    tick();
    chk_all("wrap.rel", 16'h0000, 4'd13, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_all("wrap.id2", 16'h0004, 4'd2, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_all("wrap.rel2", 16'h0000, 4'd2, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_all("wrap.id13", 16'h2000, 4'd13, 1'b1, 1'b0);

    // Withdrawal: hold one cycle, drop req[13]
    tick();
    chk_all("wd.hold", 16'h2000, 4'd13, 1'b1, 1'b0);
    req = 16'h0004;
    tick();
    chk_all("wd.rel", 16'h0000, 4'd13, 1'b0, 1'b0);
    req = 16'h0000;
    tick();
    chk_all("wd.idle", 16'h0000, 4'd13, 1'b0, 1'b0);

    // Timeout: requester 7 held for exactly 4 cycles
    req = 16'h0080;
    tick();
    chk_all("to.c1", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick();
    chk_all("to.c2", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick();
    chk_all("to.c3", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick();
    chk_all("to.c4", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick();
    chk_all("to.rev", 16'h0000, 4'd7, 1'b0, 1'b1);
    tick();
    chk_all("to.regrant", 16'h0080, 4'd7, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk_all("to2.c4", 16'h0080, 4'd7, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_all("to2.rel", 16'h0000, 4'd7, 1'b0, 1'b0);
    done = 1'b0;

    // Async reset mid-grant: ptr=8 so FFFF grants 8; reset restarts at 0
    req = 16'hFFFF;
    tick();
    chk_all("ar.grant", 16'h0100, 4'd8, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("ar.async", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("ar.first", 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
